// File: rtl/prog_load_ctrl.sv
// Serial program loader: parses a 16-bit word-count header and packs little-endian bytes into 32-bit IMEM writes.
// Optional trailing XOR checksum byte enabled by defining PROG_CHECKSUM_EN.
module prog_load_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef PROG_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0]       DEPTH_W   = 17'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state_q, state_d;
    logic              start_q, start_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       asm_q, asm_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wc_q, wc_d;
`ifdef PROG_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic        start_edge;
    logic [15:0] len_rx;
    logic        last_wr;

    assign start_edge = start & ~start_q;
    assign len_rx     = {len_q[15:8], rx_byte};
    assign last_wr    = we_q && ((wc_q + 16'd1) == len_q);

    always_comb begin
        state_d = state_q;
        start_d = start;
        len_d   = len_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wc_d    = wc_q;
`ifdef PROG_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_edge) begin
                    state_d = S_LEN_HI;
                    len_d   = '0;
                    bidx_d  = '0;
                    addr_d  = '0;
                    wc_d    = '0;
`ifdef PROG_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    len_d[15:8] = rx_byte;
                    state_d     = S_LEN_LO;
`ifdef PROG_CHECKSUM_EN
                    xor_d       = xor_q ^ rx_byte;
`endif
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_d = len_rx;
`ifdef PROG_CHECKSUM_EN
                    xor_d = xor_q ^ rx_byte;
`endif
                    if (len_rx == 16'd0) begin
`ifdef PROG_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else if ({1'b0, len_rx} > DEPTH_W) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Address/count advance in the cycle after the write strobe.
                if (we_q) begin
                    addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
                    wc_d   = wc_q + 16'd1;
                end
                if (last_wr) begin
`ifdef PROG_CHECKSUM_EN
                    // A checksum byte arriving back-to-back with the final write is consumed here.
                    if (rx_valid) state_d = (rx_byte == xor_q) ? S_DONE : S_ERR;
                    else          state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else if (rx_valid) begin
                    bidx_d = bidx_q + 2'd1;
`ifdef PROG_CHECKSUM_EN
                    xor_d  = xor_q ^ rx_byte;
`endif
                    case (bidx_q)
                        2'd0:    asm_d[7:0]   = rx_byte;
                        2'd1:    asm_d[15:8]  = rx_byte;
                        2'd2:    asm_d[23:16] = rx_byte;
                        default: begin
                            wdata_d = {rx_byte, asm_q};
                            we_d    = 1'b1;
                        end
                    endcase
                end
            end
`ifdef PROG_CHECKSUM_EN
            S_CHK: begin
                if (rx_valid) state_d = (rx_byte == xor_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            len_q   <= '0;
            bidx_q  <= '0;
            asm_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wc_q    <= '0;
`ifdef PROG_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            len_q   <= len_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
`ifdef PROG_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign busy       = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign cpu_hold   = busy;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: vector table plus hand sequences, writes checked against a scoreboard queue.
module tb_prog_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, rx_valid;
    logic [7:0]  rx_byte;
    logic        mem_we, cpu_hold, busy, done, error;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] word_count;

    prog_load_ctrl #(.ADDR_W(10), .DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        int               nb;
        logic [127:0]     b;
        int               nw;
        logic [2:0][31:0] w;
        logic             dn;
        logic             er;
        int               wc;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   nwr     = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vec[6];
    int   nv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            nwr++;
            check("we_hold", {31'd0, cpu_hold}, 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_we", {31'd0, mem_we}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {22'd0, mem_addr}, {22'd0, mon_e.a});
                check("wr_data", mem_wdata, mon_e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 50) begin
            tick();
            k++;
        end
        check({name, "_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        exp_q.push_back('{a: a[9:0], d: d});
    endtask

    task automatic chk_reset(input string name);
        check({name, "_we"},    {31'd0, mem_we},   32'd0);
        check({name, "_addr"},  {22'd0, mem_addr}, 32'd0);
        check({name, "_wdata"}, mem_wdata,         32'd0);
        check({name, "_hold"},  {31'd0, cpu_hold}, 32'd0);
        check({name, "_busy"},  {31'd0, busy},     32'd0);
        check({name, "_done"},  {31'd0, done},     32'd0);
        check({name, "_err"},   {31'd0, error},    32'd0);
        check({name, "_wc"},    {16'd0, word_count}, 32'd0);
    endtask

    function automatic vec_t mk(input int nb, input logic [127:0] raw, input int nw,
                                input logic [95:0] w, input logic dn, input logic er, input int wc);
        vec_t v;
        v.nb = nb;
        v.b  = raw << (8 * (16 - nb));
        v.nw = nw;
        v.w  = w;
        v.dn = dn;
        v.er = er;
        v.wc = wc;
        return v;
    endfunction

    initial begin
        logic [7:0] x;
`ifdef PROG_CHECKSUM_EN
        vec[0] = mk(7,  128'h0001EFBEADDE23, 1, 96'hDEADBEEF, 1'b1, 1'b0, 1);
        vec[1] = mk(15, 128'h0003_01000000_02000000_03000000_03, 3,
                    96'h00000003_00000002_00000001, 1'b1, 1'b0, 3);
        vec[2] = mk(2,  128'h0401,   0, 96'h0, 1'b0, 1'b1, 0);
        vec[3] = mk(3,  128'h000000, 0, 96'h0, 1'b1, 1'b0, 0);
        vec[4] = mk(2,  128'hFFFF,   0, 96'h0, 1'b0, 1'b1, 0);
        vec[5] = mk(3,  128'h00005A, 0, 96'h0, 1'b0, 1'b1, 0);
        nv = 6;
`else
        vec[0] = mk(6,  128'h0001EFBEADDE, 1, 96'hDEADBEEF, 1'b1, 1'b0, 1);
        vec[1] = mk(14, 128'h0003_01000000_02000000_03000000, 3,
                    96'h00000003_00000002_00000001, 1'b1, 1'b0, 3);
        vec[2] = mk(2,  128'h0401, 0, 96'h0, 1'b0, 1'b1, 0);
        vec[3] = mk(2,  128'h0000, 0, 96'h0, 1'b1, 1'b0, 0);
        vec[4] = mk(2,  128'hFFFF, 0, 96'h0, 1'b0, 1'b1, 0);
        nv = 5;
`endif
        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk_reset("rst");

        // Table-driven loads, bytes sent on consecutive cycles.
        for (int i = 0; i < nv; i++) begin
            nwr = 0;
            pulse_start();
            check($sformatf("v%0d_hold", i), {31'd0, cpu_hold}, 32'd1);
            for (int j = 0; j < vec[i].nw; j++) push_wr(j, vec[i].w[j]);
            for (int j = 0; j < vec[i].nb; j++) send(vec[i].b[127 - 8*j -: 8]);
            wait_idle($sformatf("v%0d", i));
            check($sformatf("v%0d_done", i), {31'd0, done},  {31'd0, vec[i].dn});
            check($sformatf("v%0d_err", i),  {31'd0, error}, {31'd0, vec[i].er});
            check($sformatf("v%0d_wc", i),   {16'd0, word_count}, vec[i].wc);
            check($sformatf("v%0d_addr", i), {22'd0, mem_addr}, vec[i].wc);
            check($sformatf("v%0d_hold0", i), {31'd0, cpu_hold}, 32'd0);
            check($sformatf("v%0d_nwr", i), nwr, vec[i].nw);
            check($sformatf("v%0d_sb", i), exp_q.size(), 32'd0);
        end

        // Start edge mid-load is ignored; write lands one cycle after the 4th byte.
        nwr = 0;
        pulse_start();
        push_wr(0, 32'h44332211);
        send(8'h00); send(8'h01); send(8'h11); send(8'h22);
        pulse_start();
        check("mid_start_busy", {31'd0, busy}, 32'd1);
        send(8'h33); send(8'h44);
        check("lat_we", {31'd0, mem_we}, 32'd1);
`ifdef PROG_CHECKSUM_EN
        send(8'h45);
`endif
        wait_idle("mid_start");
        check("mid_start_done", {31'd0, done}, 32'd1);
        check("mid_start_wc", {16'd0, word_count}, 32'd1);
        check("mid_start_nwr", nwr, 32'd1);

        // Bytes arriving while DONE are discarded.
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); tick();
        check("discard_wc", {16'd0, word_count}, 32'd1);
        check("discard_done", {31'd0, done}, 32'd1);
        check("discard_nwr", nwr, 32'd1);

`ifdef PROG_CHECKSUM_EN
        // Bad checksum via the CHK state: word still written.
        nwr = 0;
        pulse_start();
        push_wr(0, 32'h44332211);
        send(8'h00); send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        tick(); tick();
        check("chk_wait_busy", {31'd0, busy}, 32'd1);
        send(8'h00);
        wait_idle("badsum");
        check("badsum_err", {31'd0, error}, 32'd1);
        check("badsum_wc", {16'd0, word_count}, 32'd1);
        check("badsum_nwr", nwr, 32'd1);
`endif

        // Reset mid-word: no write, everything back to reset values.
        nwr = 0;
        pulse_start();
        send(8'h00); send(8'h01); send(8'h11); send(8'h22); send(8'h33);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset("midrst");
        tick();
        check("midrst_nwr", nwr, 32'd0);

        // Full-depth load: mem_addr wraps to 0 after address DEPTH-1.
        nwr = 0;
        x = 8'h04;
        pulse_start();
        send(8'h04); send(8'h00);
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] w;
            w = i;
            push_wr(i, w);
            for (int k = 0; k < 4; k++) begin
                send(w[8*k +: 8]);
                x ^= w[8*k +: 8];
            end
        end
`ifdef PROG_CHECKSUM_EN
        send(x);
`endif
        wait_idle("full");
        check("full_done", {31'd0, done}, 32'd1);
        check("full_wc", {16'd0, word_count}, 32'd1024);
        check("full_addr", {22'd0, mem_addr}, 32'd0);
        check("full_nwr", nwr, 32'd1024);
        check("full_sb", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
